// File: rtl/irq_pkg.sv
// Shared constants for the interrupt request front-end and its 4-line priority encoder.
package irq_pkg;

  localparam int N_IRQ     = 4;
  localparam int IRQ_IDX_W = 2;

  // Ceiling log2, with a floor of 1 so that a single line still gets a 1-bit index.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Single-bit synchroniser for an asynchronous input, SYNC_STAGES flops deep, with synchronous reset.
module bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_d;
  logic [SYNC_STAGES-1:0] sync_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/irq_request_latch.sv
// Synchronises raw request lines, latches rising edges as sticky pending bits for the
// priority encoder, clears them on acknowledge and flags events lost to an already-pending line.
module irq_request_latch
  import irq_pkg::*;
#(
  parameter int N           = N_IRQ,
  parameter int IDX_W       = IRQ_IDX_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     pend_out,
  output logic             irq_valid,
  input  logic             ack,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic             clr_all,
  output logic [N-1:0]     overflow
);

  logic [N-1:0] sync;
  logic [N-1:0] rise;
  logic [N-1:0] ack_clr;
  logic [N-1:0] prev_d;
  logic [N-1:0] prev_q;
  logic [N-1:0] pend_d;
  logic [N-1:0] pend_q;
  logic [N-1:0] ovf_d;
  logic [N-1:0] ovf_q;

  for (genvar g = 0; g < N; g++) begin : g_sync
    bit_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_bit_sync (
      .clk(clk),
      .rst(rst),
      .d  (req_in[g]),
      .q  (sync[g])
    );
  end

  assign pend_out  = pend_q & mask;
  assign irq_valid = |pend_out;
  assign overflow  = ovf_q;

  // Index values with no matching line never hit, so out-of-range ack_idx is ignored naturally.
  always_comb begin
    rise    = sync & ~prev_q;
    prev_d  = sync;
    ack_clr = '0;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < N; i++) begin
      ack_clr[i] = ack && irq_valid && (ack_idx == IDX_W'(i)) && pend_out[i];
      if (clr_all) begin
        pend_d[i] = 1'b0;
        ovf_d[i]  = 1'b0;
      end else begin
        if (rise[i]) begin
          pend_d[i] = 1'b1;
        end else if (ack_clr[i]) begin
          pend_d[i] = 1'b0;
        end
        // An edge racing an ack of its own line re-arms the bit rather than losing the event.
        if (rise[i] && pend_q[i] && !ack_clr[i]) begin
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: doc/irq_request_latch.md
Name: irq_request_latch

Overview:
- Upstream front-end for the 4-line priority encoder. Takes raw asynchronous request lines, synchronises them and detects rising edges.
- Latches each event as a sticky pending bit and presents the masked pending vector as the encoder's `d` input.
- Clears the pending bit for the index the encoder reports once the consumer acknowledges it.
- Flags lost events: a new edge arriving while that line is already pending.

Parameters:
- N, 4, number of request lines; equals the encoder input width.
- IDX_W, 2, width of the acknowledge index; equals the encoder `out` width, clog2(N).
- SYNC_STAGES, 2, synchroniser flops per request line; minimum 2.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_in  in  N  raw asynchronous request lines; an event is a rising edge.
- mask  in  N  per-line enable (1 = line may reach the encoder); synchronous to clk.
- pend_out  out  N  pending & mask; drives encoder `d`.
- irq_valid  out  1  OR-reduction of pend_out.
- ack  in  1  consumer accepts the current highest-priority request.
- ack_idx  in  IDX_W  index being acknowledged; wired from encoder `out`.
- clr_all  in  1  synchronous clear of all pending and overflow state.
- overflow  out  N  sticky per-line lost-event flags.

Behaviour:
- Reset: when rst is high at a clk edge, all synchroniser flops, the edge-history register, pending and overflow go to 0. Outputs: pend_out=0, irq_valid=0, overflow=0.
  - rst overrides ack and clr_all.
  - A reset mid-operation discards all pending events.
- Reset release with a line held high: the line is seen as a 0→1 transition and produces one pending event.
- Synchroniser: req_in[i] passes through SYNC_STAGES flops to give sync[i]. prev[i] registers sync[i]. Edge detect is rise[i] = sync[i] & ~prev[i], combinational.
- Latency: req_in rises before edge E0. For SYNC_STAGES=2: sync valid after E1, pending set at E2, so pend_out and irq_valid are high after E2 (SYNC_STAGES+1 edges).
- Pending update per bit i, highest precedence first:
  1. clr_all → 0.
  2. rise[i] → 1.
  3. ack & irq_valid & (ack_idx==i) & pend_out[i] → 0.
  4. otherwise hold.
- Consequences of the precedence:
  - A new edge in the same cycle as an ack of the same line leaves the bit set, so the event is not lost.
  - Masked lines still latch events. mask gates only the output, so unmasking later exposes the held event.
- Acknowledge: takes effect at the next edge; pend_out drops one cycle after ack.
  - ack with irq_valid=0 is ignored.
  - ack with ack_idx pointing at a non-pending or masked bit is ignored; no other bit changes.
- Overflow: overflow[i] is set when rise[i] & pending[i] & ~(ack clearing bit i in the same cycle).
  - The flag is sticky until clr_all or rst.
  - clr_all in the same cycle as an overflowing edge: clear wins.
- pend_out and irq_valid are combinational from the pending register and mask; there are no combinational paths from req_in.
- Widths: ack_idx values ≥ N are ignored; this applies only when N is not a power of two.

Decomposition:
- Shared package irq_pkg: constants N_IRQ=4 and IRQ_IDX_W=2, plus the function clog2.
- One natural sub-module: bit_sync, a SYNC_STAGES-deep single-bit synchroniser with synchronous reset, instantiated N times via generate.
- Pending, overflow and edge logic stay in the top module.

Test Plan:
- Reset and latency: rst for 2 cycles, then req_in=4'b0100 → pend_out=4'b0100 and irq_valid=1 exactly 3 edges after first sampling; encoder out=2'd2.
- Priority and ack chain: raise lines 0 and 3 together, mask=4'hF → pend_out=4'b1001.
  - ack with ack_idx=3 → pend_out=4'b0001.
  - ack with ack_idx=0 → pend_out=0, irq_valid=0.
- Mask hold: mask=4'b1101 and pulse line 1 → pend_out=0. Then mask=4'hF → pend_out=4'b0010 the same cycle, with no new edge needed.
- Ack/edge collision: line 2 pending, second rise on line 2 lands in the same cycle as ack with ack_idx=2 → pending[2] stays 1 and overflow[2]=0.
- Overflow: line 1 pending with no ack, second rising edge → overflow=4'b0010.
  - Overflow stays set through an ack of line 1.
  - clr_all → overflow=0 and pend_out=0.
- Illegal ack and reset mid-run: pend_out=4'b0100 and ack with ack_idx=1 → no change. Assert rst while 3 lines are pending → all outputs 0 at the next edge.
